// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver that turns scan codes into digit entries (0-9, clear)
// and cursor-move pulses, with parity/stop/timeout error reporting.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] user_value,
  output logic       value_valid,
  output logic       cursor_up,
  output logic       cursor_down,
  output logic       cursor_left,
  output logic       cursor_right,
  output logic       frame_error
);
  // state | meaning
  // IDLE  | waiting for a start bit (falling edge with data low)
  // RECV  | shifting data, parity and stop bits; idle timer armed
  typedef enum logic {IDLE, RECV} state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic clk_meta, clk_sync, clk_prev, data_meta, data_sync, fall;

  // Synchronizers are left unreset so a reset can never fabricate a clock edge.
  always_ff @(posedge clock) begin
    clk_meta  <= ps2_clk;
    clk_sync  <= clk_meta;
    clk_prev  <= clk_sync;
    data_meta <= ps2_data;
    data_sync <= data_meta;
  end

  assign fall = clk_prev & ~clk_sync;

  state_t          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [8:0]      shift_q, shift_d;
  logic            brk_q, brk_d, ext_q, ext_d;
  logic [3:0]      value_d;
  logic            valid_d, up_d, down_d, left_d, right_d, err_d;
  logic [7:0]      rx_byte;
  logic            frame_ok, key_is_digit;
  logic [3:0]      key_digit;

  assign rx_byte  = shift_q[7:0];
  assign frame_ok = (^shift_q) & data_sync;

  always_comb begin
    key_is_digit = 1'b1;
    key_digit    = 4'd0;
    case (rx_byte)
      8'h16, 8'h69: key_digit = 4'd1;
      8'h1E, 8'h72: key_digit = 4'd2;
      8'h26, 8'h7A: key_digit = 4'd3;
      8'h25, 8'h6B: key_digit = 4'd4;
      8'h2E, 8'h73: key_digit = 4'd5;
      8'h36, 8'h74: key_digit = 4'd6;
      8'h3D, 8'h6C: key_digit = 4'd7;
      8'h3E, 8'h75: key_digit = 4'd8;
      8'h46, 8'h7D: key_digit = 4'd9;
      8'h45, 8'h70, 8'h66: key_digit = 4'd0;
      default: key_is_digit = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tmr_d     = tmr_q;
    shift_d   = shift_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    value_d   = user_value;
    valid_d   = 1'b0;
    up_d      = 1'b0;
    down_d    = 1'b0;
    left_d    = 1'b0;
    right_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall && !data_sync) begin
          state_d   = RECV;
          bit_cnt_d = 4'd0;
          tmr_d     = TMR_LOAD;
        end
      end
      RECV: begin
        if (fall) begin
          tmr_d = TMR_LOAD;
          if (bit_cnt_q == 4'd9) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            if (!frame_ok) begin
              err_d = 1'b1;
              brk_d = 1'b0;
              ext_d = 1'b0;
            end else if (rx_byte == 8'hF0) begin
              brk_d = 1'b1;
            end else if (rx_byte == 8'hE0) begin
              ext_d = 1'b1;
            end else begin
              brk_d = 1'b0;
              ext_d = 1'b0;
              // Break-prefixed codes are key releases and produce nothing.
              if (!brk_q) begin
                if (ext_q) begin
                  case (rx_byte)
                    8'h75: up_d    = 1'b1;
                    8'h72: down_d  = 1'b1;
                    8'h6B: left_d  = 1'b1;
                    8'h74: right_d = 1'b1;
                    8'h71: begin
                      value_d = 4'd0;
                      valid_d = 1'b1;
                    end
                    default: ;
                  endcase
                end else if (key_is_digit) begin
                  value_d = key_digit;
                  valid_d = 1'b1;
                end
              end
            end
          end else begin
            shift_d   = {data_sync, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (tmr_q == '0) begin
          state_d   = IDLE;
          bit_cnt_d = 4'd0;
          err_d     = 1'b1;
          brk_d     = 1'b0;
          ext_d     = 1'b0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      tmr_q        <= '0;
      shift_q      <= '0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      user_value   <= '0;
      value_valid  <= 1'b0;
      cursor_up    <= 1'b0;
      cursor_down  <= 1'b0;
      cursor_left  <= 1'b0;
      cursor_right <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      tmr_q        <= tmr_d;
      shift_q      <= shift_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      user_value   <= value_d;
      value_valid  <= valid_d;
      cursor_up    <= up_d;
      cursor_down  <= down_d;
      cursor_left  <= left_d;
      cursor_right <= right_d;
      frame_error  <= err_d;
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: frames are bit-banged on ps2_clk/ps2_data
// and pulses are tallied by a negedge monitor.
module tb_ps2_key_decoder;
  localparam int TMO = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] user_value;
  logic       value_valid, cursor_up, cursor_down, cursor_left, cursor_right, frame_error;

  int checks = 0, errors = 0;
  int cyc = 0, stop_cyc = 0;
  int n_valid = 0, n_up = 0, n_down = 0, n_left = 0, n_right = 0, n_err = 0, n_multi = 0;
  int last_valid_cyc = -1, last_err_cyc = -1;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .user_value(user_value), .value_valid(value_valid),
    .cursor_up(cursor_up), .cursor_down(cursor_down),
    .cursor_left(cursor_left), .cursor_right(cursor_right),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (value_valid)  begin n_valid++; last_valid_cyc = cyc; end
    if (cursor_up)    n_up++;
    if (cursor_down)  n_down++;
    if (cursor_left)  n_left++;
    if (cursor_right) n_right++;
    if (frame_error)  begin n_err++; last_err_cyc = cyc; end
    if (int'(value_valid) + int'(cursor_up) + int'(cursor_down) + int'(cursor_left)
        + int'(cursor_right) + int'(frame_error) > 1) n_multi++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(4);
    ps2_clk  = 1'b0;
    stop_cyc = cyc;
    tick(8);
    ps2_clk  = 1'b1;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_parity);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ bad_parity);
    send_bit(1'b1);
    tick(4);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits - 1; i++) send_bit(b[i]);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(4);
    checks++; if (user_value !== 4'd0) begin errors++; $display("FAIL reset_value got %0d want 0", user_value); end
    checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", value_valid); end
    checks++; if ({cursor_up, cursor_down, cursor_left, cursor_right} !== 4'b0000) begin
      errors++; $display("FAIL reset_cursor got %b want 0000", {cursor_up, cursor_down, cursor_left, cursor_right}); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", frame_error); end
    reset = 1'b0;
    tick(4);
  endtask

  task automatic test_digit;
    int v0, o0;
    v0 = n_valid; o0 = n_up + n_down + n_left + n_right + n_err;
    send_byte(8'h1E, 1'b0);
    checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL digit_pulses got %0d want 1", n_valid - v0); end
    checks++; if (last_valid_cyc - stop_cyc != 3) begin errors++; $display("FAIL digit_latency got %0d want 3", last_valid_cyc - stop_cyc); end
    checks++; if (user_value !== 4'd2) begin errors++; $display("FAIL digit_value got %0d want 2", user_value); end
    checks++; if (n_up + n_down + n_left + n_right + n_err - o0 != 0) begin
      errors++; $display("FAIL digit_other got %0d want 0", n_up + n_down + n_left + n_right + n_err - o0); end
  endtask

  task automatic test_cursor_up;
    int u0, v0;
    u0 = n_up; v0 = n_valid;
    send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
    checks++; if (n_up - u0 != 1) begin errors++; $display("FAIL up_make got %0d want 1", n_up - u0); end
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
    checks++; if (n_up - u0 != 1) begin errors++; $display("FAIL up_release got %0d want 1", n_up - u0); end
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL up_valid got %0d want 0", n_valid - v0); end
    checks++; if (user_value !== 4'd2) begin errors++; $display("FAIL up_value got %0d want 2", user_value); end
  endtask

  task automatic test_release;
    int v0;
    v0 = n_valid;
    send_byte(8'h46, 1'b0);
    checks++; if (user_value !== 4'd9) begin errors++; $display("FAIL rel_make got %0d want 9", user_value); end
    send_byte(8'hF0, 1'b0); send_byte(8'h46, 1'b0);
    send_byte(8'h45, 1'b0);
    checks++; if (user_value !== 4'd0) begin errors++; $display("FAIL rel_zero got %0d want 0", user_value); end
    checks++; if (n_valid - v0 != 2) begin errors++; $display("FAIL rel_pulses got %0d want 2", n_valid - v0); end
  endtask

  task automatic test_parity;
    int e0, v0;
    e0 = n_err; v0 = n_valid;
    send_byte(8'h16, 1'b1);
    checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL par_err got %0d want 1", n_err - e0); end
    checks++; if (last_err_cyc - stop_cyc != 3) begin errors++; $display("FAIL par_latency got %0d want 3", last_err_cyc - stop_cyc); end
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL par_valid got %0d want 0", n_valid - v0); end
    checks++; if (user_value !== 4'd0) begin errors++; $display("FAIL par_value got %0d want 0", user_value); end
  endtask

  task automatic test_timeout;
    int e0, u0;
    e0 = n_err;
    send_partial(8'h26, 4);
    tick(TMO + 40);
    checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL tmo_err got %0d want 1", n_err - e0); end
    send_byte(8'h26, 1'b0);
    checks++; if (user_value !== 4'd3) begin errors++; $display("FAIL tmo_next got %0d want 3", user_value); end
    u0 = n_up;
    send_byte(8'hE0, 1'b0);
    send_partial(8'h75, 4);
    tick(TMO + 40);
    send_byte(8'h75, 1'b0);
    checks++; if (n_err - e0 != 2) begin errors++; $display("FAIL tmo_err2 got %0d want 2", n_err - e0); end
    checks++; if (user_value !== 4'd8 || n_up != u0) begin
      errors++; $display("FAIL tmo_extclr got value %0d ups %0d want 8 0", user_value, n_up - u0); end
  endtask

  task automatic test_reset_mid;
    send_byte(8'h16, 1'b0);
    checks++; if (user_value !== 4'd1) begin errors++; $display("FAIL rmid_pre got %0d want 1", user_value); end
    send_partial(8'h3E, 6);
    reset = 1'b1;
    tick(3);
    checks++; if ({user_value, value_valid, cursor_up, cursor_down, cursor_left, cursor_right, frame_error} !== 10'd0) begin
      errors++; $display("FAIL rmid_outputs got %b want 0", {user_value, value_valid, cursor_up, cursor_down, cursor_left, cursor_right, frame_error}); end
    reset = 1'b0;
    tick(3);
    send_byte(8'h3E, 1'b0);
    checks++; if (user_value !== 4'd8) begin errors++; $display("FAIL rmid_next got %0d want 8", user_value); end
  endtask

  task automatic test_extended;
    int d0, l0, r0, v0;
    d0 = n_down; l0 = n_left; r0 = n_right;
    send_byte(8'hE0, 1'b0); send_byte(8'h72, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'h6B, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'h74, 1'b0);
    checks++; if (n_down - d0 != 1 || n_left - l0 != 1 || n_right - r0 != 1) begin
      errors++; $display("FAIL ext_cursors got d%0d l%0d r%0d want 1 1 1", n_down - d0, n_left - l0, n_right - r0); end
    checks++; if (user_value !== 4'd8) begin errors++; $display("FAIL ext_hold got %0d want 8", user_value); end
    v0 = n_valid;
    send_byte(8'hE0, 1'b0); send_byte(8'h71, 1'b0);
    checks++; if (user_value !== 4'd0 || n_valid - v0 != 1) begin
      errors++; $display("FAIL ext_delete got value %0d pulses %0d want 0 1", user_value, n_valid - v0); end
  endtask

  task automatic test_keypad;
    logic [7:0] codes [7];
    logic [3:0] want  [7];
    codes = '{8'h69, 8'h7A, 8'h6C, 8'h7D, 8'h70, 8'h3D, 8'h66};
    want  = '{4'd1,  4'd3,  4'd7,  4'd9,  4'd0,  4'd7,  4'd0};
    for (int i = 0; i < 7; i++) begin
      send_byte(codes[i], 1'b0);
      checks++; if (user_value !== want[i]) begin
        errors++; $display("FAIL keypad_%h got %0d want %0d", codes[i], user_value, want[i]); end
    end
  endtask

  task automatic test_unmapped;
    int v0, u0;
    v0 = n_valid; u0 = n_up;
    send_byte(8'hE0, 1'b0); send_byte(8'h1C, 1'b0);
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL unmapped_valid got %0d want 0", n_valid - v0); end
    send_byte(8'h75, 1'b0);
    checks++; if (user_value !== 4'd8 || n_up != u0) begin
      errors++; $display("FAIL unmapped_flagclr got value %0d ups %0d want 8 0", user_value, n_up - u0); end
  endtask

  task automatic test_idle_edge;
    ps2_data = 1'b1;
    tick(4);
    ps2_clk = 1'b0;
    tick(8);
    ps2_clk = 1'b1;
    tick(8);
    send_byte(8'h25, 1'b0);
    checks++; if (user_value !== 4'd4) begin errors++; $display("FAIL idle_edge got %0d want 4", user_value); end
  endtask

  task automatic test_error_clears_break;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h46, 1'b1);
    send_byte(8'h46, 1'b0);
    checks++; if (user_value !== 4'd9) begin errors++; $display("FAIL err_brkclr got %0d want 9", user_value); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    send_byte(8'h16, 1'b0);
    send_byte(8'h16, 1'b0);
    checks++; if (n_valid - v0 != 2) begin errors++; $display("FAIL repeat_pulses got %0d want 2", n_valid - v0); end
    checks++; if (user_value !== 4'd1) begin errors++; $display("FAIL repeat_value got %0d want 1", user_value); end
  endtask

  initial begin
    test_reset();
    test_digit();
    test_cursor_up();
    test_release();
    test_parity();
    test_timeout();
    test_reset_mid();
    test_extended();
    test_keypad();
    test_unmapped();
    test_idle_edge();
    test_error_clears_break();
    test_back_to_back();
    checks++; if (n_multi != 0) begin errors++; $display("FAIL exclusive got %0d want 0", n_multi); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
